// File: rtl/fifo_wr_ctrl.sv
// Write-side frame sequencer: waits for FIFO headroom, then writes a 4-word preamble and FRAME_LEN samples.
// Define FIFO_WR_CTRL_CKSUM_EN to append a mod-2^DATA_W payload checksum word to each frame.
module fifo_wr_ctrl #(
    parameter int DATA_W     = 12,
    parameter int FRAME_LEN  = 1024,
    parameter int FIFO_DEPTH = 2048,
    parameter int LVL_W      = 12
) (
    input  logic              rx_clk_i,
    input  logic              rst_n_i,
    input  logic              en_i,
    input  logic              start_i,
    input  logic              clr_ovf_i,
    input  logic [DATA_W-1:0] smp_data_i,
    input  logic              smp_valid_i,
    input  logic              fifo_full_i,
    input  logic [LVL_W-1:0]  fifo_level_i,
    output logic              fifo_wr_en_o,
    output logic [DATA_W-1:0] fifo_wr_data_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              ovf_o,
    output logic [15:0]       frame_cnt_o
);

`ifdef FIFO_WR_CTRL_CKSUM_EN
    localparam int TRAIL_WORDS = 1;
    typedef enum logic [2:0] {IDLE, WAIT_SPACE, HDR, PAYLOAD, TRAIL} state_t;
`else
    localparam int TRAIL_WORDS = 0;
    typedef enum logic [2:0] {IDLE, WAIT_SPACE, HDR, PAYLOAD} state_t;
`endif

    localparam int NEED     = FRAME_LEN + 4 + TRAIL_WORDS;
    localparam int CNT_W    = $clog2(FRAME_LEN + 2);
    localparam int LAST_INT = FRAME_LEN - 1;

    localparam logic [LVL_W:0]   DEPTH_X  = FIFO_DEPTH[LVL_W:0];
    localparam logic [LVL_W:0]   NEED_X   = NEED[LVL_W:0];
    localparam logic [CNT_W-1:0] FULL_CNT = FRAME_LEN[CNT_W-1:0];
    localparam logic [CNT_W-1:0] LAST_IDX = LAST_INT[CNT_W-1:0];

    state_t            state_q, state_d;
    logic [1:0]        hdr_cnt_q, hdr_cnt_d;
    logic [CNT_W-1:0]  pay_cnt_q, pay_cnt_d;
    logic              wr_en_q, wr_en_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              ovf_q, ovf_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;
`ifdef FIFO_WR_CTRL_CKSUM_EN
    logic [DATA_W-1:0] cksum_q, cksum_d;
`endif

    // One extra bit so a level above FIFO_DEPTH goes negative and never reads as space.
    logic [LVL_W:0] headroom;
    logic           space_ok;
    assign headroom = DEPTH_X - {1'b0, fifo_level_i};
    assign space_ok = !headroom[LVL_W] && (headroom >= NEED_X);

    function automatic logic [DATA_W-1:0] hdr_word(input logic [1:0] idx);
        case (idx)
            2'd0:    return DATA_W'(12'hACD);
            2'd1:    return DATA_W'(12'hFFF);
            2'd2:    return DATA_W'(12'hEBE);
            default: return DATA_W'(12'hFDC);
        endcase
    endfunction

    always_comb begin
        state_d   = state_q;
        hdr_cnt_d = hdr_cnt_q;
        pay_cnt_d = pay_cnt_q;
        wr_en_d   = 1'b0;
        wr_data_d = wr_data_q;
        done_d    = 1'b0;
        ovf_d     = ovf_q & ~clr_ovf_i;
`ifdef FIFO_WR_CTRL_CKSUM_EN
        cksum_d   = cksum_q;
`endif
        case (state_q)
            IDLE: begin
                if (start_i && en_i) begin
                    state_d   = WAIT_SPACE;
                    pay_cnt_d = '0;
`ifdef FIFO_WR_CTRL_CKSUM_EN
                    cksum_d   = '0;
`endif
                end
            end
            WAIT_SPACE: begin
                if (space_ok) begin
                    wr_en_d   = 1'b1;
                    wr_data_d = hdr_word(2'd0);
                    hdr_cnt_d = 2'd1;
                    state_d   = HDR;
                end
            end
            HDR: begin
                wr_en_d   = 1'b1;
                wr_data_d = hdr_word(hdr_cnt_q);
                hdr_cnt_d = hdr_cnt_q + 2'd1;
                if (hdr_cnt_q == 2'd3) state_d = PAYLOAD;
            end
            PAYLOAD: begin
                // A full payload count means the done cycle has passed; linger one cycle so busy drops after done.
                if (pay_cnt_q == FULL_CNT) begin
                    state_d = IDLE;
                end else if (smp_valid_i) begin
                    if (fifo_full_i) begin
                        ovf_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        wr_en_d   = 1'b1;
                        wr_data_d = smp_data_i;
                        pay_cnt_d = pay_cnt_q + CNT_W'(1);
`ifdef FIFO_WR_CTRL_CKSUM_EN
                        cksum_d   = cksum_q + smp_data_i;
                        if (pay_cnt_q == LAST_IDX) state_d = TRAIL;
`else
                        if (pay_cnt_q == LAST_IDX) done_d = 1'b1;
`endif
                    end
                end
            end
`ifdef FIFO_WR_CTRL_CKSUM_EN
            TRAIL: begin
                if (pay_cnt_q == FULL_CNT) begin
                    wr_en_d   = 1'b1;
                    wr_data_d = cksum_q;
                    done_d    = 1'b1;
                    pay_cnt_d = pay_cnt_q + CNT_W'(1);
                end else begin
                    state_d = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
        if (done_d) ovf_d = ovf_d;
        frame_cnt_d = frame_cnt_q + {15'd0, done_d};
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge rx_clk_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            hdr_cnt_q   <= '0;
            pay_cnt_q   <= '0;
            wr_en_q     <= 1'b0;
            wr_data_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ovf_q       <= 1'b0;
            frame_cnt_q <= '0;
`ifdef FIFO_WR_CTRL_CKSUM_EN
            cksum_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            hdr_cnt_q   <= hdr_cnt_d;
            pay_cnt_q   <= pay_cnt_d;
            wr_en_q     <= wr_en_d;
            wr_data_q   <= wr_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            ovf_q       <= ovf_d;
            frame_cnt_q <= frame_cnt_d;
`ifdef FIFO_WR_CTRL_CKSUM_EN
            cksum_q     <= cksum_d;
`endif
        end
    end

    assign fifo_wr_en_o   = wr_en_q;
    assign fifo_wr_data_o = wr_data_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign ovf_o          = ovf_q;
    assign frame_cnt_o    = frame_cnt_q;

endmodule
